// File: rtl/tm1638_key_reader.sv
// -----------------------------------------------------------------------------
// tm1638_key_reader
//
// Reads the 8 front-panel keys of a TM1638 LED&KEY board over STB/CLK/DIO.
// Each accepted start sends the read command 0x42 (LSB first) and then
// releases DIO. After the Twait gap it clocks in four scan bytes b0..b3,
// also LSB first. The bytes are decoded into keys[7:0] and done pulses.
//
// Optional feature (macro TM_KEY_EDGE_EN):
//   When the macro is defined, a key_press output is added. It carries the
//   keys that were newly pressed since the previous scan, for one cycle
//   together with done. When the macro is undefined, the port and its logic
//   are absent.
//
// Parameters
//   CLK_DIV   clk cycles per tm_clk half-period (>=1)
//   WAIT_CYC  clk cycles between the command and the first read bit (>=1)
//
// Ports
//   clk        in   system clock, all logic on posedge
//   rst        in   synchronous active-high reset
//   start      in   request one scan (accepted only when idle)
//   busy       out  high while a scan is in progress
//   done       out  one-cycle pulse; keys valid from this cycle
//   keys[7:0]  out  key state, 1 = pressed, keys[i] = S(i+1)
//   stb        out  TM1638 STB, active low
//   tm_clk     out  TM1638 CLK, idles high
//   dio_out    out  DIO drive value
//   dio_oe     out  DIO output enable (tristate buffer lives outside)
//   dio_in     in   DIO sampled value
//   key_press  out  (TM_KEY_EDGE_EN only) newly pressed keys, pulses with done
// -----------------------------------------------------------------------------
module tm1638_key_reader #(
  parameter int CLK_DIV  = 50,
  parameter int WAIT_CYC = 100
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  output logic       busy,
  output logic       done,
  output logic [7:0] keys,
  output logic       stb,
  output logic       tm_clk,
  output logic       dio_out,
  output logic       dio_oe,
  input  logic       dio_in
`ifdef TM_KEY_EDGE_EN
  ,
  output logic [7:0] key_press
`endif
);

  localparam int DIV_MAX = (2 * CLK_DIV > WAIT_CYC) ? 2 * CLK_DIV : WAIT_CYC;
  localparam int DW      = $clog2(DIV_MAX + 1);

  localparam logic [DW-1:0] HALF_LAST = DW'(CLK_DIV - 1);
  localparam logic [DW-1:0] SLOT_LAST = DW'(2 * CLK_DIV - 1);
  localparam logic [DW-1:0] WAIT_LAST = DW'(WAIT_CYC - 1);
  localparam logic [7:0]    CMD_BYTE  = 8'h42;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    CMD  = 3'd1,
    WAIT = 3'd2,
    READ = 3'd3,
    STOP = 3'd4
  } state_t;

  state_t        state;
  logic [DW-1:0] div_cnt;
  logic [5:0]    bit_cnt;
  logic [7:0]    cmd_sr;     // remaining command bits, next one in [0]
  logic [7:0]    key_shadow; // keys of the scan in progress

  // Scan sequencer: command, wait gap, 32 read slots, stop, with registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      div_cnt    <= '0;
      bit_cnt    <= 6'd0;
      cmd_sr     <= 8'h00;
      key_shadow <= 8'h00;
      busy       <= 1'b0;
      done       <= 1'b0;
      keys       <= 8'h00;
      stb        <= 1'b1;
      tm_clk     <= 1'b1;
      dio_out    <= 1'b1;
      dio_oe     <= 1'b0;
`ifdef TM_KEY_EDGE_EN
      key_press  <= 8'h00;
`endif
    end else begin
      done <= 1'b0;
`ifdef TM_KEY_EDGE_EN
      key_press <= 8'h00;
`endif
      case (state)
        IDLE: begin
          if (start) begin
            // First command slot starts right away: CLK falls together with
            // the first data bit being driven.
            state      <= CMD;
            busy       <= 1'b1;
            stb        <= 1'b0;
            tm_clk     <= 1'b0;
            dio_oe     <= 1'b1;
            dio_out    <= CMD_BYTE[0];
            cmd_sr     <= {1'b0, CMD_BYTE[7:1]};
            div_cnt    <= '0;
            bit_cnt    <= 6'd0;
            key_shadow <= 8'h00;
          end else begin
            state <= IDLE;
          end
        end

        CMD: begin
          if (div_cnt == HALF_LAST) begin
            tm_clk  <= 1'b1;
            div_cnt <= div_cnt + 1'b1;
          end else if (div_cnt == SLOT_LAST) begin
            div_cnt <= '0;
            if (bit_cnt == 6'd7) begin
              // Release DIO; CLK stays high through the wait gap.
              state   <= WAIT;
              dio_oe  <= 1'b0;
              dio_out <= 1'b1;
              bit_cnt <= 6'd0;
            end else begin
              bit_cnt <= bit_cnt + 6'd1;
              tm_clk  <= 1'b0;
              dio_out <= cmd_sr[0];
              cmd_sr  <= {1'b0, cmd_sr[7:1]};
            end
          end else begin
            div_cnt <= div_cnt + 1'b1;
          end
        end

        WAIT: begin
          if (div_cnt == WAIT_LAST) begin
            state   <= READ;
            tm_clk  <= 1'b0;
            div_cnt <= '0;
            bit_cnt <= 6'd0;
          end else begin
            div_cnt <= div_cnt + 1'b1;
          end
        end

        READ: begin
          if (div_cnt == HALF_LAST) begin
            tm_clk  <= 1'b1;
            div_cnt <= div_cnt + 1'b1;
            // Only bits 0 and 4 of each byte carry keys. Bit n of byte i maps
            // to key i (n=0) or key i+4 (n=4), so the key index is
            // {bit_cnt[2], bit_cnt[4:3]} whenever bit_cnt[1:0] is zero.
            if (bit_cnt[1:0] == 2'b00) begin
              key_shadow[{bit_cnt[2], bit_cnt[4:3]}] <= dio_in;
            end else begin
              key_shadow <= key_shadow;
            end
          end else if (div_cnt == SLOT_LAST) begin
            div_cnt <= '0;
            if (bit_cnt == 6'd31) begin
              state <= STOP;
              stb   <= 1'b1;
            end else begin
              bit_cnt <= bit_cnt + 6'd1;
              tm_clk  <= 1'b0;
            end
          end else begin
            div_cnt <= div_cnt + 1'b1;
          end
        end

        STOP: begin
          if (div_cnt == SLOT_LAST) begin
            // keys is replaced in one step, so it is never partially updated.
            state   <= IDLE;
            div_cnt <= '0;
            busy    <= 1'b0;
            done    <= 1'b1;
            keys    <= key_shadow;
`ifdef TM_KEY_EDGE_EN
            key_press <= key_shadow & ~keys;
`endif
          end else begin
            div_cnt <= div_cnt + 1'b1;
          end
        end

        default: begin
          state   <= IDLE;
          busy    <= 1'b0;
          stb     <= 1'b1;
          tm_clk  <= 1'b1;
          dio_out <= 1'b1;
          dio_oe  <= 1'b0;
        end
      endcase
    end
  end

endmodule
